// File: rtl/mmm_pkg.sv
// Shared front-end constants: instruction cache geometry and fetch buffer depth.
package mmm_pkg;
    localparam int ICACHE_LINE_LEN = 128;
    localparam int ILEN            = 32;
    localparam int ICACHE_OFFSET   = 4;
    localparam int FETCH_BUF_DEPTH = 2;
endpackage

// File: rtl/fetch_line_buffer_slot_mux.sv
// Selects one instruction slot out of a cache line; purely combinational.
module instr_slot_mux #(
    parameter int LINE_LEN  = 128,
    parameter int INSTR_LEN = 32,
    localparam int N_SLOTS  = LINE_LEN / INSTR_LEN,
    localparam int OFF_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic [LINE_LEN-1:0]  line_i,
    input  logic [OFF_W-1:0]     slot_i,
    output logic [INSTR_LEN-1:0] instr_o
);

    always_comb begin
        instr_o = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_i == OFF_W'(k)) begin
                instr_o = line_i[k*INSTR_LEN +: INSTR_LEN];
            end
        end
    end

endmodule

// File: rtl/fetch_line_buffer.sv
// Circular queue of fetched cache lines that streams one instruction per cycle
// to decode, tagging each with its PC; supports redirect start offsets and flush.
module fetch_line_buffer
    import mmm_pkg::*;
#(
    parameter int LINE_LEN  = ICACHE_LINE_LEN,
    parameter int INSTR_LEN = ILEN,
    parameter int DEPTH     = FETCH_BUF_DEPTH,
    parameter int ADDR_W    = 32,
    localparam int N_SLOTS  = LINE_LEN / INSTR_LEN,
    localparam int OFF_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 line_valid_i,
    output logic                 line_ready_o,
    input  logic [LINE_LEN-1:0]  line_i,
    input  logic [ADDR_W-1:0]    line_addr_i,
    input  logic [OFF_W-1:0]     start_off_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [INSTR_LEN-1:0] instr_o,
    output logic [ADDR_W-1:0]    instr_pc_o,
    output logic [CNT_W-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OFF_W-1:0] LAST_SLOT = OFF_W'(N_SLOTS - 1);
    localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(INSTR_LEN / 8);

    typedef struct packed {
        logic [LINE_LEN-1:0] line;
        logic [ADDR_W-1:0]   addr;
        logic [OFF_W-1:0]    off;
    } entry_t;

    entry_t           entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OFF_W-1:0] rd_idx_q, rd_idx_d;

    logic   push, issue, pop;
    entry_t head;

    // Explicit wrap so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes on both sides are plain valid/ready: a transfer happens on a
    // rising edge where valid and ready are both high; valid never depends on
    // ready. flush_i drops both line_ready_o and instr_valid_o combinationally,
    // and line_ready_o never depends on instr_ready_i (no push while full).
    assign line_ready_o  = (count_q < CNT_W'(DEPTH)) & ~flush_i;
    assign instr_valid_o = (count_q != '0) & ~flush_i;
    assign push          = line_valid_i & line_ready_o;
    assign issue         = instr_valid_o & instr_ready_i;
    assign pop           = issue & (rd_idx_q == LAST_SLOT);

    assign head       = entries_q[rd_ptr_q];
    assign instr_pc_o = head.addr + ADDR_W'(rd_idx_q) * INSTR_BYTES;
    assign count_o    = count_q;

    instr_slot_mux #(
        .LINE_LEN  (LINE_LEN),
        .INSTR_LEN (INSTR_LEN)
    ) u_slot_mux (
        .line_i  (head.line),
        .slot_i  (rd_idx_q),
        .instr_o (instr_o)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rd_idx_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // A line arriving as the sole entry drains starts at its redirect offset.
            if (pop) begin
                if (count_q == CNT_W'(1)) rd_idx_d = push ? start_off_i : '0;
                else                      rd_idx_d = entries_q[ptr_inc(rd_ptr_q)].off;
            end else if (issue) begin
                rd_idx_d = rd_idx_q + OFF_W'(1);
            end else if (push && count_q == '0) begin
                rd_idx_d = start_off_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_idx_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (push) begin
            entries_q[wr_ptr_q] <= '{line: line_i, addr: line_addr_i, off: start_off_i};
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed table-driven bench for fetch_line_buffer (128-bit lines, 32-bit instrs, depth 2).
module tb_fetch_line_buffer;

  localparam int LINE_LEN  = 128;
  localparam int INSTR_LEN = 32;
  localparam int DEPTH     = 2;
  localparam int ADDR_W    = 32;
  localparam int OFF_W     = 2;
  localparam int CNT_W     = 2;

  typedef struct {
    logic        flush;
    logic        lv;
    logic [31:0] addr;
    logic [31:0] base;
    logic [1:0]  off;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [1:0]  e_count;
    logic        e_lr;
  } vec_t;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 line_valid;
  logic                 line_ready;
  logic [LINE_LEN-1:0]  line;
  logic [ADDR_W-1:0]    line_addr;
  logic [OFF_W-1:0]     start_off;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_LEN-1:0] instr;
  logic [ADDR_W-1:0]    instr_pc;
  logic [CNT_W-1:0]     count;

  int   checks;
  int   failures;
  vec_t vec_q[$];

  fetch_line_buffer #(
    .LINE_LEN  (LINE_LEN),
    .INSTR_LEN (INSTR_LEN),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .line_valid_i  (line_valid),
    .line_ready_o  (line_ready),
    .line_i        (line),
    .line_addr_i   (line_addr),
    .start_off_i   (start_off),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .count_o       (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic v(input logic f, input logic lv, input logic [31:0] addr, input logic [31:0] base,
                   input logic [1:0] off, input logic rdy, input logic ev, input logic [31:0] ei,
                   input logic [31:0] epc, input logic [1:0] ecnt, input logic elr);
    vec_t t;
    t.flush = f; t.lv = lv; t.addr = addr; t.base = base; t.off = off; t.rdy = rdy;
    t.e_valid = ev; t.e_instr = ei; t.e_pc = epc; t.e_count = ecnt; t.e_lr = elr;
    vec_q.push_back(t);
  endtask

  // driver: inputs change at negedge, outputs sampled 1 time unit later
  task automatic drive(input logic f, input logic lv, input logic [31:0] addr, input logic [31:0] base,
                       input logic [1:0] off, input logic rdy);
    flush       = f;
    line_valid  = lv;
    line_addr   = addr;
    line        = mk_line(base);
    start_off   = off;
    instr_ready = rdy;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ei,
                               input logic [31:0] epc, input logic [1:0] ecnt, input logic elr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
    chk({tag, ".count"}, {30'd0, count}, {30'd0, ecnt});
    chk({tag, ".line_ready"}, {31'd0, line_ready}, {31'd0, elr});
    if (ev) begin
      chk({tag, ".instr"}, instr, ei);
      chk({tag, ".pc"}, instr_pc, epc);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // single line, start 0, four consecutive issues
    v(0,1,32'h1000,32'h11110000,0,1, 0,0,0,0,1);
    v(0,0,0,0,0,1, 1,32'h11110000,32'h1000,1,1);
    v(0,0,0,0,0,1, 1,32'h11110001,32'h1004,1,1);
    v(0,0,0,0,0,1, 1,32'h11110002,32'h1008,1,1);
    v(0,0,0,0,0,1, 1,32'h11110003,32'h100C,1,1);
    // start offset 2
    v(0,1,32'h2000,32'h22220000,2,1, 0,0,0,0,1);
    v(0,0,0,0,0,1, 1,32'h22220002,32'h2008,1,1);
    v(0,0,0,0,0,1, 1,32'h22220003,32'h200C,1,1);
    // fill while stalled, then drain and accept the third line
    v(0,1,32'h4000,32'h33330000,0,0, 0,0,0,0,1);
    v(0,1,32'h5000,32'h44440000,0,0, 1,32'h33330000,32'h4000,1,1);
    v(0,1,32'h6000,32'h55550000,0,1, 1,32'h33330000,32'h4000,2,0);
    v(0,1,32'h6000,32'h55550000,0,1, 1,32'h33330001,32'h4004,2,0);
    v(0,1,32'h6000,32'h55550000,0,1, 1,32'h33330002,32'h4008,2,0);
    v(0,1,32'h6000,32'h55550000,0,1, 1,32'h33330003,32'h400C,2,0);
    v(0,1,32'h6000,32'h55550000,0,1, 1,32'h44440000,32'h5000,1,1);
    v(0,0,0,0,0,1, 1,32'h44440001,32'h5004,2,0);
    v(0,0,0,0,0,1, 1,32'h44440002,32'h5008,2,0);
    v(0,0,0,0,0,1, 1,32'h44440003,32'h500C,2,0);
    v(0,0,0,0,0,1, 1,32'h55550000,32'h6000,1,1);
    v(0,0,0,0,0,1, 1,32'h55550001,32'h6004,1,1);
    v(0,0,0,0,0,1, 1,32'h55550002,32'h6008,1,1);
    // push coinciding with the last issue of the only entry: no bubble
    v(0,1,32'h3000,32'h66660000,1,1, 1,32'h55550003,32'h600C,1,1);
    v(0,0,0,0,0,1, 1,32'h66660001,32'h3004,1,1);
    v(0,0,0,0,0,1, 1,32'h66660002,32'h3008,1,1);
    // fill to two, then flush with a line offered
    v(0,1,32'h7000,32'h77770000,0,0, 1,32'h66660003,32'h300C,1,1);
    v(1,1,32'h8000,32'h88880000,0,1, 0,0,0,2,0);
    v(0,0,0,0,0,1, 0,0,0,0,1);
    v(0,0,0,0,0,1, 0,0,0,0,1);

    // reset state
    #2;
    chk("reset.valid", {31'd0, instr_valid}, 32'd0);
    chk("reset.count", {30'd0, count}, 32'd0);
    chk("reset.line_ready", {31'd0, line_ready}, 32'd1);
    chk("reset.instr", instr, 32'd0);
    chk("reset.pc", instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vec_q[i]) begin
      @(negedge clk);
      drive(vec_q[i].flush, vec_q[i].lv, vec_q[i].addr, vec_q[i].base, vec_q[i].off, vec_q[i].rdy);
      #1;
      check_outputs($sformatf("vec%0d", i), vec_q[i].e_valid, vec_q[i].e_instr,
                    vec_q[i].e_pc, vec_q[i].e_count, vec_q[i].e_lr);
    end

    // asynchronous reset mid-drain, then restart from a fresh start offset
    @(negedge clk);
    drive(0, 1, 32'hA000, 32'hAAAA0000, 0, 1);
    #1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check_outputs("rst.s0", 1, 32'hAAAA0000, 32'hA000, 1, 1);
    @(negedge clk);
    #1;
    check_outputs("rst.s1", 1, 32'hAAAA0001, 32'hA004, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.async.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.async.count", {30'd0, count}, 32'd0);
    chk("rst.async.instr", instr, 32'd0);
    chk("rst.async.pc", instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 32'h9000, 32'h99990000, 3, 1);
    #1;
    check_outputs("rst.push", 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check_outputs("rst.restart", 1, 32'h99990003, 32'h900C, 1, 1);
    @(negedge clk);
    #1;
    check_outputs("rst.empty", 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Parametrised fetch-line queue between the instruction cache and decode. It buffers up to DEPTH cache lines, each tagged with its line base address and first valid slot. It streams one instruction per cycle with a valid/ready handshake and computes each instruction's PC. It replaces single-line register/backup selection with a generalised, depth-configurable buffer that supports redirect offsets and flush.

## Interface
Parameters:
- LINE_LEN, default ICACHE_LINE_LEN: cache line width in bits; must be a multiple of INSTR_LEN.
- INSTR_LEN, default ILEN: instruction width in bits; must be a multiple of 8.
- DEPTH, default FETCH_BUF_DEPTH (2): number of line entries, ≥1.
- ADDR_W, default 32: PC width.
- Derived: N_SLOTS = LINE_LEN/INSTR_LEN, which must be a power of two. OFF_W = log2(N_SLOTS), with a minimum of 1. CNT_W = log2(DEPTH+1).

Ports:
- clk_i, in, 1: clock. Single clock domain, rising edge.
- rst_n_i, in, 1: asynchronous active-low reset.
- flush_i, in, 1: discard all buffered lines (redirect or mispredict).
- line_valid_i, in, 1: cache line offered.
- line_ready_o, out, 1: buffer accepts line.
- line_i, in, LINE_LEN: line data; slot k = bits [k*INSTR_LEN +: INSTR_LEN].
- line_addr_i, in, ADDR_W: line-aligned base address.
- start_off_i, in, OFF_W: first slot to issue from this line.
- instr_valid_o, out, 1: instr_o/instr_pc_o valid.
- instr_ready_i, in, 1: decode consumes instruction.
- instr_o, out, INSTR_LEN: current instruction.
- instr_pc_o, out, ADDR_W: PC of instr_o.
- count_o, out, CNT_W: number of occupied entries.

## Operation
- Storage is a circular FIFO of DEPTH entries, each holding {line, addr, off}. It uses write pointer wr_ptr, read pointer rd_ptr and count. Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
- Register rd_idx (OFF_W bits) is the slot index within the head entry.
- line_ready_o = (count < DEPTH) & ~flush_i. There is no push-while-full, even with a simultaneous pop.
- Push occurs when line_valid_i & line_ready_o. The entry is written at wr_ptr, wr_ptr advances and count increments.
- instr_valid_o = (count != 0) & ~flush_i.
- instr_o = head.line slot rd_idx.
- instr_pc_o = head.addr + rd_idx*(INSTR_LEN/8), computed modulo 2^ADDR_W.
- Issue occurs when instr_valid_o & instr_ready_i. If rd_idx < N_SLOTS-1, rd_idx increments. Otherwise the head is popped: rd_ptr advances, count decrements, and rd_idx loads the next entry's off.
- rd_idx loads start_off_i on a push into an empty buffer, or on a push coinciding with a pop of the only entry.
- On simultaneous push and pop, count is unchanged and both pointers advance.
- flush_i has priority over everything. At the next edge count, rd_ptr, wr_ptr and rd_idx are all 0. A line offered in the flush cycle is not accepted, because line_ready_o is 0.
- Out-of-range start_off_i cannot occur, because the port width equals OFF_W.

## Timing
- Reset values (asynchronous, immediate on rst_n_i low): count_o=0, instr_valid_o=0, line_ready_o=1 (with flush_i low), instr_o=0, instr_pc_o=0. All storage, pointers and rd_idx are cleared.
- Latency: a line pushed at edge k has its first instruction valid from edge k onward. The first issue is in the cycle after acceptance; there is no input-to-output bypass.
- Throughput: one instruction per cycle, with no bubble across line boundaries when the next entry is present.
- Combinational paths: flush_i to line_ready_o and instr_valid_o. There is no path from instr_ready_i to line_ready_o.
- Reset during operation aborts any transfer; the buffer restarts empty.

## Structure
- mmm_pkg gains FETCH_BUF_DEPTH. ICACHE_LINE_LEN, ILEN and ICACHE_OFFSET stay there.
- The entry struct is declared locally, because it depends on the parameters.
- Sub-module instr_slot_mux: purely combinational. Takes the line and a slot index and returns INSTR_LEN bits, parametrised on LINE_LEN and INSTR_LEN. It is instantiated once on the head entry.

## Test plan
All scenarios use LINE_LEN=128, INSTR_LEN=32, DEPTH=2, ADDR_W=32.
- Push line 0x1000 with words {A,B,C,D}, start_off 0, instr_ready_i=1 → A@0x1000, B@0x1004, C@0x1008, D@0x100C on four consecutive cycles, then instr_valid_o=0 and count_o=0.
- Push 0x2000 with start_off=2 → only slot2@0x2008 and slot3@0x200C are issued.
- With instr_ready_i=0, push two lines → count_o=2 and line_ready_o=0. After four issues, line_ready_o=1 and the third line is accepted.
- With count=1 and rd_idx=3, push line 0x3000 (start_off 1) in the same cycle as the last issue → the next cycle outputs slot1@0x3004 with no bubble, and count_o stays 1.
- With count=2, assert flush_i together with line_valid_i → line_ready_o=0 and instr_valid_o=0 in that cycle. The next cycle has count_o=0, and the offered line is not issued.
- Assert rst_n_i low mid-cycle while draining → instr_valid_o=0 and count_o=0 before the next edge. After release, a new push issues from its start_off.
